adder_n_core: RTL and testbench

N-bit binary adder with carry-in and carry-out, used as the arithmetic primitive for datapath blocks. Provides an unregistered combinational result for in-cycle use and a one-cycle registered copy with a valid flag for pipelined consumers. The carry chain is structural: one full-adder cell per bit.

---
 rtl/adder_n_core_if.sv | 48 ++++
 rtl/adder_n_core.sv | 102 ++++++++++
 tb/tb_adder_n_core.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_n_core_if.sv
// adder_n_core_if -- bus bundle for adder_n_core.
//
// Groups the operand/result signals of the N-bit adder so that a producer
// (master) and the adder (slave) share one connection.
//   a, b       : N-bit operands (unsigned or two's complement)
//   c_in       : carry into bit 0
//   in_valid   : qualifies a/b/c_in for the registered path
//   sum, c_out : combinational result
//   sum_q, c_out_q, out_valid : registered result and its valid flag
//   overflow, overflow_q      : signed-overflow flags, only when
//                               ADDER_N_OVERFLOW_EN is defined
interface adder_n_core_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         in_valid;
  logic [N-1:0] sum;
  logic         c_out;
  logic [N-1:0] sum_q;
  logic         c_out_q;
  logic         out_valid;
`ifdef ADDER_N_OVERFLOW_EN
  logic         overflow;
  logic         overflow_q;

  modport master (
    output a, b, c_in, in_valid,
    input  sum, c_out, sum_q, c_out_q, out_valid, overflow, overflow_q
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output sum, c_out, sum_q, c_out_q, out_valid, overflow, overflow_q
  );
`else
  modport master (
    output a, b, c_in, in_valid,
    input  sum, c_out, sum_q, c_out_q, out_valid
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output sum, c_out, sum_q, c_out_q, out_valid
  );
`endif
endinterface

// File: rtl/adder_n_core.sv
// adder_n_core -- N-bit ripple-carry adder with carry-in/carry-out.
//
// Produces an unregistered result {c_out, sum} = a + b + c_in for in-cycle
// use, plus a one-cycle registered copy (sum_q, c_out_q) qualified by
// out_valid for pipelined consumers. The carry chain is built from one
// full-adder cell per bit.
//
// Ports:
//   clk   : rising-edge clock for the registered path
//   rst_n : asynchronous active-low reset (clears registered path only)
//   bus   : adder_n_core_if.slave (a, b, c_in, in_valid in;
//           sum, c_out, sum_q, c_out_q, out_valid out)
//
// Optional feature: define ADDER_N_OVERFLOW_EN to add the signed-overflow
// outputs overflow (combinational) and overflow_q (registered alongside
// sum_q). Parameter N: operand width, legal range 1..64.

// Single-bit full adder cell of the carry chain.
module adder_n_core_fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  logic p;

  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);
endmodule

module adder_n_core #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_n_core_if.slave  bus
);

  // carry[i] is the carry into bit i; carry[N] is the carry out.
  logic [N:0]   carry;
  logic [N-1:0] sum_w;

  logic [N-1:0] sum_r;
  logic         c_out_r;
  logic         valid_r;

  assign carry[0] = bus.c_in;

  for (genvar i = 0; i < N; i++) begin : g_bit
    adder_n_core_fa u_fa (
      .a     (bus.a[i]),
      .b     (bus.b[i]),
      .c_in  (carry[i]),
      .s     (sum_w[i]),
      .c_out (carry[i+1])
    );
  end

  assign bus.sum   = sum_w;
  assign bus.c_out = carry[N];

  // Result registers hold when in_valid is low; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r   <= '0;
      c_out_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        sum_r   <= sum_w;
        c_out_r <= carry[N];
      end
    end
  end

  assign bus.sum_q     = sum_r;
  assign bus.c_out_q   = c_out_r;
  assign bus.out_valid = valid_r;

`ifdef ADDER_N_OVERFLOW_EN
  logic ovf_w;
  logic ovf_r;

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf_w = carry[N] ^ carry[N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_r <= ovf_w;
    end
  end

  assign bus.overflow   = ovf_w;
  assign bus.overflow_q = ovf_r;
`endif

endmodule

// File: tb/tb_adder_n_core.sv
// Self-checking bench for adder_n_core at N = 1, 8 and 32.
module tb_adder_n_core;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  adder_n_core_if #(.N(1))  if1  ();
  adder_n_core_if #(.N(8))  if8  ();
  adder_n_core_if #(.N(32)) if32 ();

  adder_n_core #(.N(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  adder_n_core #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  adder_n_core #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full (n+1)-bit unsigned sum of the n-bit operands.
  function automatic logic [64:0] ref_add(input int unsigned n, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin);
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
  endfunction

  function automatic logic [64:0] ref_sum(input int unsigned n, input logic [64:0] full);
    logic [64:0] mask;
    mask = (65'd1 << n) - 65'd1;
    return full & mask;
  endfunction

  // Signed overflow: true result lies outside the n-bit two's complement range.
  function automatic logic ref_ovf(input int unsigned n, input logic [63:0] a,
                                   input logic [63:0] b, input logic cin);
    longint sa, sb, sr, lim;
    lim = longint'(1) <<< (n - 1);
    sa  = longint'(a & ((64'd1 << n) - 64'd1));
    sb  = longint'(b & ((64'd1 << n) - 64'd1));
    if (a[n-1]) sa = sa - (lim * 2);
    if (b[n-1]) sb = sb - (lim * 2);
    sr = sa + sb + longint'(cin);
    return (sr > lim - 1) || (sr < -lim);
  endfunction

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic v);
    if8.a = a; if8.b = b; if8.c_in = cin; if8.in_valid = v;
  endtask

  logic [63:0] ra, rb;
  logic        rc, rv;
  logic [64:0] full;
  logic [7:0]  exp_q;
  logic        exp_cq, exp_v;
`ifdef ADDER_N_OVERFLOW_EN
  logic        exp_oq;
`endif

  initial begin
    rst_n = 1'b0;
    drive8(8'd0, 8'd0, 1'b0, 1'b0);
    if1.a = '0;  if1.b = '0;  if1.c_in = 1'b0;  if1.in_valid = 1'b0;
    if32.a = '0; if32.b = '0; if32.c_in = 1'b0; if32.in_valid = 1'b0;
    #1;
    check("rst_sum_q", 65'(if8.sum_q), 65'd0);
    check("rst_c_out_q", 65'(if8.c_out_q), 65'd0);
    check("rst_out_valid", 65'(if8.out_valid), 65'd0);
    check("rst_out_valid32", 65'(if32.out_valid), 65'd0);
    check("zero_sum", 65'(if8.sum), 65'd0);
    check("zero_c_out", 65'(if8.c_out), 65'd0);
`ifdef ADDER_N_OVERFLOW_EN
    check("rst_overflow_q", 65'(if8.overflow_q), 65'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    // Directed combinational vectors, N = 8.
    drive8(8'd2, 8'd2, 1'b0, 1'b0);       #1;
    check("d_2p2_sum", 65'(if8.sum), 65'd4);
    check("d_2p2_cout", 65'(if8.c_out), 65'd0);
    drive8(8'hFF, 8'd1, 1'b0, 1'b0);      #1;
    check("d_ff1_sum", 65'(if8.sum), 65'd0);
    check("d_ff1_cout", 65'(if8.c_out), 65'd1);
    drive8(8'hFF, 8'hFF, 1'b1, 1'b0);     #1;
    check("d_ffff1_sum", 65'(if8.sum), 65'hFF);
    check("d_ffff1_cout", 65'(if8.c_out), 65'd1);
    drive8(8'd127, 8'd128, 1'b1, 1'b0);   #1;
    check("d_127_128_1_sum", 65'(if8.sum), 65'd0);
    check("d_127_128_1_cout", 65'(if8.c_out), 65'd1);
`ifdef ADDER_N_OVERFLOW_EN
    check("d_127_128_1_ovf", 65'(if8.overflow), 65'd0);
    drive8(8'd127, 8'd1, 1'b0, 1'b0);     #1;
    check("d_127_1_sum", 65'(if8.sum), 65'd128);
    check("d_127_1_ovf", 65'(if8.overflow), 65'd1);
`endif

    // Random combinational vectors across all widths.
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
      if1.a = ra[0:0]; if1.b = rb[0:0]; if1.c_in = rc;
      if8.a = ra[7:0]; if8.b = rb[7:0]; if8.c_in = rc;
      if32.a = ra[31:0]; if32.b = rb[31:0]; if32.c_in = rc;
      #1;
      full = ref_add(1, ra, rb, rc);
      check("r1_sum", 65'(if1.sum), ref_sum(1, full));
      check("r1_cout", 65'(if1.c_out), 65'(full[1]));
      full = ref_add(8, ra, rb, rc);
      check("r8_sum", 65'(if8.sum), ref_sum(8, full));
      check("r8_cout", 65'(if8.c_out), 65'(full[8]));
      full = ref_add(32, ra, rb, rc);
      check("r32_sum", 65'(if32.sum), ref_sum(32, full));
      check("r32_cout", 65'(if32.c_out), 65'(full[32]));
`ifdef ADDER_N_OVERFLOW_EN
      check("r1_ovf", 65'(if1.overflow), 65'(ref_ovf(1, ra, rb, rc)));
      check("r8_ovf", 65'(if8.overflow), 65'(ref_ovf(8, ra, rb, rc)));
      check("r32_ovf", 65'(if32.overflow), 65'(ref_ovf(32, ra, rb, rc)));
`endif
      #1;
    end

    // Registered path: capture then hold.
    @(negedge clk);
    drive8(8'd10, 8'd20, 1'b0, 1'b1);
    @(negedge clk);
    check("q_capture_sum", 65'(if8.sum_q), 65'd30);
    check("q_capture_cout", 65'(if8.c_out_q), 65'd0);
    check("q_capture_valid", 65'(if8.out_valid), 65'd1);
    drive8(8'd5, 8'd6, 1'b1, 1'b0);
    @(negedge clk);
    check("q_hold_sum", 65'(if8.sum_q), 65'd30);
    check("q_hold_valid", 65'(if8.out_valid), 65'd0);

    // Random registered stream against a capture-on-valid model.
    exp_q = 8'd30; exp_cq = 1'b0; exp_v = 1'b0;
`ifdef ADDER_N_OVERFLOW_EN
    exp_oq = ref_ovf(8, 64'd10, 64'd20, 1'b0);
`endif
    for (int i = 0; i < 300; i++) begin
      ra = {32'd0, $urandom}; rb = {32'd0, $urandom}; rc = 1'($urandom); rv = 1'($urandom);
      drive8(ra[7:0], rb[7:0], rc, rv);
      full = ref_add(8, ra, rb, rc);
      exp_v = rv;
      if (rv) begin
        exp_q  = full[7:0];
        exp_cq = full[8];
`ifdef ADDER_N_OVERFLOW_EN
        exp_oq = ref_ovf(8, ra, rb, rc);
`endif
      end
      @(negedge clk);
      check("qr_sum", 65'(if8.sum_q), 65'(exp_q));
      check("qr_cout", 65'(if8.c_out_q), 65'(exp_cq));
      check("qr_valid", 65'(if8.out_valid), 65'(exp_v));
`ifdef ADDER_N_OVERFLOW_EN
      check("qr_ovf", 65'(if8.overflow_q), 65'(exp_oq));
`endif
    end

    // Asynchronous reset between edges while a result is valid.
    drive8(8'd200, 8'd100, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    check("ar_pre_valid", 65'(if8.out_valid), 65'd1);
    check("ar_pre_sum", 65'(if8.sum_q), 65'd44);
    check("ar_pre_cout", 65'(if8.c_out_q), 65'd1);
    rst_n = 1'b0;
    #1;
    check("ar_sum_q", 65'(if8.sum_q), 65'd0);
    check("ar_c_out_q", 65'(if8.c_out_q), 65'd0);
    check("ar_out_valid", 65'(if8.out_valid), 65'd0);
    check("ar_comb_sum", 65'(if8.sum), 65'd44);
    check("ar_comb_cout", 65'(if8.c_out), 65'd1);
    @(posedge clk);
    #1;
    check("ar_held_valid", 65'(if8.out_valid), 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive8(8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("ar_idle_sum_q", 65'(if8.sum_q), 65'd0);
    check("ar_idle_valid", 65'(if8.out_valid), 65'd0);
    drive8(8'd7, 8'd8, 1'b1, 1'b1);
    @(negedge clk);
    check("ar_first_sum", 65'(if8.sum_q), 65'd16);
    check("ar_first_valid", 65'(if8.out_valid), 65'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
